// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: single-outstanding core-to-memory bus controller with valid/ack handshake, wait states and timeout.
module mem_bus_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int TIMEOUT = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = '0
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iReq,
  input  logic              iWr,
  input  logic [ADDR_W-1:0] iAddr,
  input  logic [DATA_W-1:0] iWData,
  input  logic              iErrClr,
  output logic              oRdy,
  output logic [DATA_W-1:0] oRData,
  output logic              oErr,
  output logic              oBus_Valid,
  output logic              oBus_Wr,
  output logic [ADDR_W-1:0] oBus_Addr,
  output logic [DATA_W-1:0] oBus_WData,
  input  logic              iBus_Ack,
  input  logic [DATA_W-1:0] iBus_RData
);
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERROR} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic wr_q;
  logic tmo;
  assign tmo = (state == ACCESS) && !iBus_Ack && (TIMEOUT != 0) && (cnt == LAST);
  assign oBus_Valid = (state == ACCESS);
  assign oBus_Wr = oBus_Valid && wr_q;
  assign oRdy = ((state == IDLE) && !iReq) || (state == DONE) || (state == ERROR);
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = iReq ? ACCESS : IDLE;
      ACCESS:  state_n = iBus_Ack ? DONE : (tmo ? ERROR : ACCESS);
      default: state_n = IDLE;
    endcase
  end
  // ERR_DATA and the sticky flag are loaded on the timeout edge so the ERROR cycle already shows them
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state      <= IDLE;
      cnt        <= '0;
      wr_q       <= 1'b0;
      oBus_Addr  <= '0;
      oBus_WData <= '0;
      oRData     <= '0;
      oErr       <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && iReq) begin
        oBus_Addr  <= iAddr;
        oBus_WData <= iWData;
        wr_q       <= iWr;
        cnt        <= '0;
      end
      if (state == ACCESS && !iBus_Ack && TIMEOUT != 0) cnt <= cnt + CW'(1);
      if (state == ACCESS && iBus_Ack && !wr_q) oRData <= iBus_RData;
      if (tmo) oRData <= ERR_DATA;
      oErr <= tmo || (oErr && !iErrClr);
    end
  end
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: directed and randomized transactions checked against a transaction-level model.
module tb_mem_bus_ctrl;
  localparam int TO = 8;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
  logic iClk = 1'b0;
  logic iRst, iReq, iWr, iErrClr, iBus_Ack;
  logic [31:0] iAddr, iWData, iBus_RData;
  logic oRdy, oErr, oBus_Valid, oBus_Wr;
  logic [31:0] oRData, oBus_Addr, oBus_WData;
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_rdata;
  logic m_err;

  mem_bus_ctrl #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
    .iClk(iClk), .iRst(iRst), .iReq(iReq), .iWr(iWr), .iAddr(iAddr), .iWData(iWData),
    .iErrClr(iErrClr), .oRdy(oRdy), .oRData(oRData), .oErr(oErr), .oBus_Valid(oBus_Valid),
    .oBus_Wr(oBus_Wr), .oBus_Addr(oBus_Addr), .oBus_WData(oBus_WData),
    .iBus_Ack(iBus_Ack), .iBus_RData(iBus_RData)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transaction: ack_at is the 1-based ACCESS cycle carrying the ack (0 or > TO means none in time).
  task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int ack_at, input logic [31:0] rd, input logic hold, input logic clr);
    bit acked, done;
    int vexp, vcnt;
    acked = (ack_at >= 1) && (ack_at <= TO);
    vexp = acked ? ack_at : TO;
    vcnt = 0;
    done = 0;
    @(negedge iClk);
    iReq = 1'b1; iWr = wr; iAddr = addr; iWData = wdata;
    iBus_Ack = 1'($urandom_range(0, 1)); iBus_RData = $urandom;
    #1;
    chk("req_rdy", 32'(oRdy), 0);
    chk("req_valid", 32'(oBus_Valid), 0);
    for (int n = 1; n <= 4 * TO && !done; n++) begin
      @(negedge iClk);
      iReq = hold; iWr = 1'($urandom); iAddr = $urandom; iWData = $urandom;
      iBus_Ack = (n == ack_at);
      iBus_RData = (n == ack_at) ? rd : $urandom;
      iErrClr = clr && (n <= vexp);
      #1;
      if (oBus_Valid) begin
        vcnt++;
        chk("bus_addr", oBus_Addr, addr);
        chk("bus_wdata", oBus_WData, wdata);
        chk("bus_wr", 32'(oBus_Wr), 32'(wr));
        chk("acc_rdy", 32'(oRdy), 0);
      end else begin
        done = 1;
        if (acked && !wr) m_rdata = rd;
        if (!acked) m_rdata = ERRD;
        m_err = clr ? !acked : (m_err || !acked);
        chk("valid_cycles", 32'(vcnt), 32'(vexp));
        chk("end_rdy", 32'(oRdy), 1);
        chk("end_rdata", oRData, m_rdata);
        chk("end_err", 32'(oErr), 32'(m_err));
        chk("end_wr", 32'(oBus_Wr), 0);
      end
    end
    if (!done) chk("ready_bound", 0, 1);
    iBus_Ack = 1'b0; iErrClr = 1'b0;
  endtask

  initial begin
    iRst = 1'b1; iReq = 1'b0; iWr = 1'b0; iErrClr = 1'b0; iBus_Ack = 1'b0;
    iAddr = '0; iWData = '0; iBus_RData = '0;
    m_rdata = '0; m_err = 1'b0;
    repeat (2) @(negedge iClk);
    iRst = 1'b0;
    #1;
    chk("rst_rdy", 32'(oRdy), 1);
    chk("rst_valid", 32'(oBus_Valid), 0);
    chk("rst_rdata", oRData, 0);
    chk("rst_err", 32'(oErr), 0);
    chk("rst_addr", oBus_Addr, 0);
    chk("rst_wdata", oBus_WData, 0);
    access(1'b0, 32'h100, 32'h0, 3, 32'h1234_5678, 1'b0, 1'b0);
    access(1'b1, 32'h20, 32'hCAFE_F00D, 1, 32'h0, 1'b0, 1'b0);
    access(1'b0, 32'h40, 32'h0, 0, 32'h0, 1'b0, 1'b0);
    @(negedge iClk); #1;
    chk("err_sticky", 32'(oErr), 1);
    // reset in the 2nd ACCESS cycle, then a late ack
    @(negedge iClk); iReq = 1'b1; iWr = 1'b0; iAddr = 32'h100;
    @(negedge iClk); iReq = 1'b0; iAddr = 32'hFFFF;
    #1;
    chk("hold_addr", oBus_Addr, 32'h100);
    @(negedge iClk); iRst = 1'b1;
    @(negedge iClk); iRst = 1'b0; iBus_Ack = 1'b1; iBus_RData = 32'h5A5A_5A5A;
    #1;
    m_rdata = '0; m_err = 1'b0;
    chk("mrst_valid", 32'(oBus_Valid), 0);
    chk("mrst_rdy", 32'(oRdy), 1);
    chk("mrst_rdata", oRData, 0);
    chk("mrst_err", 32'(oErr), 0);
    chk("mrst_addr", oBus_Addr, 0);
    @(negedge iClk); iBus_Ack = 1'b0;
    #1;
    chk("late_ack_rdata", oRData, 0);
    chk("late_ack_valid", 32'(oBus_Valid), 0);
    access(1'b0, 32'h44, 32'h0, 0, 32'h0, 1'b0, 1'b0);
    @(negedge iClk); iErrClr = 1'b1;
    @(negedge iClk); iErrClr = 1'b0;
    #1;
    m_err = 1'b0;
    chk("err_clr", 32'(oErr), 0);
    // back-to-back with iReq held through DONE
    access(1'b0, 32'h300, 32'h0, 2, 32'h0BAD_F00D, 1'b1, 1'b0);
    access(1'b1, 32'h304, 32'h1111_2222, 1, 32'h0, 1'b1, 1'b0);
    access(1'b0, 32'h308, 32'h0, 1, 32'h7777_8888, 1'b0, 1'b0);
    for (int t = 0; t < 60; t++)
      access(1'($urandom), $urandom, $urandom, $urandom_range(0, TO + 2), $urandom,
             1'($urandom), ($urandom_range(0, 3) == 0));
    iReq = 1'b0;
    @(negedge iClk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
